// File: rtl/mem_init_arbiter_pkg.sv
// Shared definitions for the RAM init sequencer / two-client arbiter.
package mem_init_arbiter_pkg;

    typedef enum logic [2:0] {
        RESET_INIT,
        INIT_REQ,
        INIT_REL,
        SERVE,
        DRAIN
    } state_t;

    localparam int NUM_CLI = 2;
    localparam int CLI0    = 0;
    localparam int CLI1    = 1;

endpackage

// File: rtl/mem_init_arbiter_rr_arb2.sv
// Two-way round-robin picker: masked requesters, one-hot winner, pointer update.
module mem_init_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       ptrNext
);

    logic [1:0] elig;
    assign elig = req & ~mask;

    always_comb begin
        win     = 2'b00;
        ptrNext = ptr;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
        // Pointer always moves past whoever was just served.
        if (win[0])      ptrNext = 1'b1;
        else if (win[1]) ptrNext = 1'b0;
    end

endmodule

// File: rtl/mem_init_arbiter.sv
// Owns the RAM port: runs the init sweep after reset/reinit, then round-robins two clients.
module mem_init_arbiter
    import mem_init_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter logic [DATA_W-1:0] INIT_DATA = '0,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reinit,
    output logic              init_en,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_done,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ready,
    output logic              init_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [CW-1:0]     tmoCnt;
    logic              ptr;
    logic              rdOk;
    logic [1:0]        win;
    logic              ptrNext;
    logic              tmoHit;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selWe;

    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH);
    endfunction

    mem_init_arbiter_rr_arb2 u_arb (
        .req    (req),
        .mask   (gnt),
        .ptr    (ptr),
        .win    (win),
        .ptrNext(ptrNext)
    );

    assign tmoHit   = (tmoCnt == CW'(TIMEOUT));
    assign selAddr  = win[CLI1] ? addr1  : addr0;
    assign selWdata = win[CLI1] ? wdata1 : wdata0;
    assign selWe    = win[CLI1] ? we[CLI1] : we[CLI0];

    // Read data comes straight off the RAM; out-of-range reads had no RAM access.
    assign rdata = (rdOk && |rvalid) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_INIT;
            tmoCnt    <= '0;
            ptr       <= 1'b0;
            rdOk      <= 1'b0;
            init_en   <= 1'b0;
            gnt       <= '0;
            rvalid    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ready     <= 1'b0;
            init_err  <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            gnt    <= '0;
            rvalid <= gnt & {2{~mem_we}};
            rdOk   <= mem_en;
            case (state)
                RESET_INIT: begin
                    state   <= INIT_REQ;
                    init_en <= 1'b1;
                    tmoCnt  <= '0;
                end
                INIT_REQ: begin
                    if (init_valid && inRange(init_addr)) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= init_addr;
                        mem_wdata <= INIT_DATA;
                    end
                    if (init_done || tmoHit) begin
                        state   <= INIT_REL;
                        init_en <= 1'b0;
                        tmoCnt  <= '0;
                        if (!init_done) init_err <= 1'b1;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end
                INIT_REL: begin
                    if (!init_done || tmoHit) begin
                        state <= SERVE;
                        ready <= 1'b1;
                        if (init_done) init_err <= 1'b1;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end
                SERVE: begin
                    if (reinit) begin
                        state <= DRAIN;
                        ready <= 1'b0;
                    end else if (|win) begin
                        gnt       <= win;
                        mem_en    <= inRange(selAddr);
                        mem_we    <= selWe;
                        mem_addr  <= selAddr;
                        mem_wdata <= selWdata;
                        ptr       <= ptrNext;
                    end
                end
                DRAIN: begin
                    // A grant still visible here means its rvalid lands next cycle.
                    if (gnt == '0) begin
                        state   <= INIT_REQ;
                        init_en <= 1'b1;
                        tmoCnt  <= '0;
                    end
                end
                default: state <= RESET_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_init_arbiter.sv
// Scoreboard bench: init engine + RAM models, two client drivers, negedge monitor.
module tb_mem_init_arbiter;

    localparam int DEPTH = 32;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} cmd_t;
    typedef struct packed {logic [1:0] rv; logic [31:0] data;} rd_t;

    logic        clk = 0, rst_n = 1, tRst_n = 1, reinit = 0;
    logic        init_en, init_valid, init_done;
    logic [31:0] init_addr;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [1:0]  req, we, gnt, rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, ready, init_err;

    logic        tInitEn, tMemEn, tMemWe, tReady, tInitErr;
    logic [1:0]  tGnt, tRvalid;
    logic [31:0] tRdata, tMemAddr, tMemWdata;

    assign req = {req1, req0};
    assign we  = {we1, we0};

    always #5 clk = ~clk;

    mem_init_arbiter dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .init_en(init_en),
        .init_valid(init_valid), .init_addr(init_addr), .init_done(init_done),
        .req(req), .we(we), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ready(ready), .init_err(init_err)
    );

    // Second instance: engine never completes, short timeout.
    mem_init_arbiter #(.TIMEOUT(15)) tDut (
        .clk(clk), .rst_n(tRst_n), .reinit(1'b0), .init_en(tInitEn),
        .init_valid(1'b0), .init_addr(32'h0), .init_done(1'b0),
        .req(2'b00), .we(2'b00), .addr0(32'h0), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
        .gnt(tGnt), .rvalid(tRvalid), .rdata(tRdata), .mem_en(tMemEn), .mem_we(tMemWe),
        .mem_addr(tMemAddr), .mem_wdata(tMemWdata), .mem_rdata(32'h0),
        .ready(tReady), .init_err(tInitErr)
    );

    // Init engine model: 2-flop enable sync, sweeps 0..DEPTH, then holds done.
    logic eS1, eS2;
    int   eCnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eS1 <= 0; eS2 <= 0; init_valid <= 0; init_addr <= 0; init_done <= 0; eCnt <= 0;
        end else begin
            eS1 <= init_en;
            eS2 <= eS1;
            init_valid <= 0;
            if (!eS2) begin
                init_done <= 0;
                eCnt <= 0;
            end else if (!init_done) begin
                if (eCnt <= DEPTH) begin
                    init_valid <= 1;
                    init_addr  <= 32'(eCnt);
                    eCnt       <= eCnt + 1;
                end else begin
                    init_done <= 1;
                end
            end
        end
    end

    // RAM model, 1-cycle read latency.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[4:0]];
        end
    end

    cmd_t       cliQ0[$], cliQ1[$], expCmd[$];
    logic [1:0] expGnt[$];
    rd_t        expRd[$];
    int         nCmp = 0, nErr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        nCmp++;
        nErr++;
        $display("FAIL %s: got %0h expected nothing", nm, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something.
    logic [1:0] prevGnt = 0;
    always @(negedge clk) begin
        if (|gnt) begin
            if (expGnt.size() == 0) unexpected("gnt", 64'(gnt));
            else chk("gnt", 64'(gnt), 64'(expGnt.pop_front()));
        end
        if (mem_en) begin
            if (expCmd.size() == 0) unexpected("mem_cmd", {mem_we, mem_addr});
            else chk("mem_cmd", 64'({mem_we, mem_addr, mem_wdata}), 64'(expCmd.pop_front()));
        end
        if (|rvalid) begin
            chk("rvalid_after_gnt", 64'(rvalid & ~prevGnt), 64'h0);
            if (expRd.size() == 0) unexpected("rvalid", 64'(rvalid));
            else begin
                rd_t e;
                e = expRd.pop_front();
                chk("rvalid", 64'(rvalid), 64'(e.rv));
                chk("rdata", 64'(rdata), 64'(e.data));
            end
        end
        prevGnt = gnt;
    end

    initial begin : drv0
        cmd_t t;
        forever begin
            @(negedge clk);
            if (req0 && gnt[0]) req0 = 0;
            if (!req0 && cliQ0.size() > 0) begin
                t = cliQ0.pop_front();
                req0 = 1; we0 = t.we; addr0 = t.addr; wdata0 = t.data;
            end
        end
    end

    initial begin : drv1
        cmd_t t;
        forever begin
            @(negedge clk);
            if (req1 && gnt[1]) req1 = 0;
            if (!req1 && cliQ1.size() > 0) begin
                t = cliQ1.pop_front();
                req1 = 1; we1 = t.we; addr1 = t.addr; wdata1 = t.data;
            end
        end
    end

    // Queue one client transaction plus its hand-computed expectations.
    task automatic go(input int c, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rdv);
        cmd_t t;
        rd_t  r;
        t = '{we: w, addr: a, data: d};
        if (c == 0) cliQ0.push_back(t);
        else        cliQ1.push_back(t);
        expGnt.push_back(c == 0 ? 2'b01 : 2'b10);
        if (a < DEPTH) expCmd.push_back(t);
        if (!w) begin
            r = '{rv: (c == 0 ? 2'b01 : 2'b10), data: rdv};
            expRd.push_back(r);
        end
    endtask

    task automatic pushInit();
        cmd_t t;
        for (int i = 0; i < DEPTH; i++) begin
            t = '{we: 1'b1, addr: 32'(i), data: 32'h0};
            expCmd.push_back(t);
        end
    endtask

    task automatic waitIdle(input string nm);
        int n;
        n = 0;
        while ((cliQ0.size() + cliQ1.size() + expGnt.size() + expCmd.size() + expRd.size()) != 0
               || req0 || req1) begin
            if (n >= 400) break;
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(cliQ0.size() + cliQ1.size() + expGnt.size() + expCmd.size() + expRd.size()), 64'h0);
    endtask

    task automatic waitReady(input string nm);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(ready), 64'h1);
    endtask

    task automatic chkOutsZero(input string p);
        chk({p, "_init_en"}, 64'(init_en), 0);
        chk({p, "_gnt"}, 64'(gnt), 0);
        chk({p, "_rvalid"}, 64'(rvalid), 0);
        chk({p, "_rdata"}, 64'(rdata), 0);
        chk({p, "_mem_en"}, 64'(mem_en), 0);
        chk({p, "_mem_we"}, 64'(mem_we), 0);
        chk({p, "_mem_addr"}, 64'(mem_addr), 0);
        chk({p, "_mem_wdata"}, 64'(mem_wdata), 0);
        chk({p, "_ready"}, 64'(ready), 0);
        chk({p, "_init_err"}, 64'(init_err), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        #1 rst_n = 0; tRst_n = 0;
        #2 chkOutsZero("rst");
        pushInit();
        @(negedge clk);
        rst_n = 1; tRst_n = 1;

        // init_en rises on the first edge after release, in both instances
        @(posedge clk); #1;
        chk("init_en_cycle1", 64'(init_en), 1);
        chk("t_init_en_cycle1", 64'(tInitEn), 1);
        // timeout instance: error exactly 16 cycles after init_en rise
        repeat (15) @(posedge clk);
        #1 chk("t_init_err_early", 64'(tInitErr), 0);
        @(posedge clk); #1;
        chk("t_init_err", 64'(tInitErr), 1);
        chk("t_init_en_low", 64'(tInitEn), 0);
        @(posedge clk); #1;
        chk("t_ready", 64'(tReady), 1);

        waitReady("init_ready");
        chk("init_err_clean", 64'(init_err), 0);
        chk("init_done_low", 64'(init_done), 0);
        waitIdle("init_sweep");

        // both clients stream writes: grants alternate 01,10,01,10
        @(posedge clk); #1;
        go(0, 1, 32'd1, 32'h1111_00A1, 0);
        go(1, 1, 32'd2, 32'h2222_00B2, 0);
        go(0, 1, 32'd3, 32'h3333_00A3, 0);
        go(1, 1, 32'd4, 32'h4444_00B4, 0);
        waitIdle("rr_writes");

        go(1, 1, 32'd5, 32'hDEAD_BEEF, 0);
        waitIdle("wr5");
        go(0, 0, 32'd5, 0, 32'hDEAD_BEEF);
        waitIdle("rd5");

        // address boundary: last word, exactly DEPTH, and beyond
        go(1, 1, 32'd31, 32'h0000_3131, 0);
        waitIdle("wr31");
        go(0, 0, 32'd31, 0, 32'h0000_3131);
        waitIdle("rd31");
        go(0, 0, 32'd32, 0, 0);
        waitIdle("rd_oob32");
        go(1, 0, 32'd40, 0, 0);
        waitIdle("rd_oob40");
        go(0, 1, 32'd33, 32'h0000_0055, 0);
        waitIdle("wr_oob33");
        go(1, 0, 32'd1, 0, 32'h1111_00A1);
        waitIdle("rd1_untouched");

        // reinit with a read in flight: read completes, then full resweep
        go(0, 0, 32'd5, 0, 32'hDEAD_BEEF);
        pushInit();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[0] && n < 50);
        chk("reinit_gnt_seen", 64'(gnt[0]), 1);
        reinit = 1;
        @(negedge clk);
        reinit = 0;
        chk("drain_ready", 64'(ready), 0);
        go(1, 1, 32'd7, 32'h0000_0077, 0);
        waitReady("reinit_ready");
        waitIdle("reinit_sweep");
        go(0, 0, 32'd5, 0, 0);
        waitIdle("rd5_cleared");
        go(1, 0, 32'd7, 0, 32'h0000_0077);
        waitIdle("rd7");
        chk("init_err_after_reinit", 64'(init_err), 0);

        // reset asserted mid-sweep at address 10
        pushInit();
        @(negedge clk); reinit = 1;
        @(negedge clk); reinit = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_en && mem_addr == 32'd10) && n < 100);
        chk("midrst_addr10_seen", 64'(mem_addr), 64'd10);
        #2 rst_n = 0;
        #1 chkOutsZero("midrst");
        expCmd.delete();
        pushInit();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("resweep_init_en", 64'(init_en), 1);
        waitReady("resweep_ready");
        waitIdle("resweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/mem_init_arbiter.md
Name: mem_init_arbiter

Overview:
- Owns the single write/read port of a DEPTH-word synchronous RAM.
- After reset, and on request, it sequences the memory-init engine by driving init_en and forwarding its address sweep as RAM writes.
- Once init is complete, it round-robin arbitrates the RAM port between two client requesters.
- Sits between the init engine, the client logic and the RAM macro.

Parameters:
ADDR_W, 32, address width (matches init engine address output)
DATA_W, 32, RAM data width
DEPTH, 32, RAM words; init writes with address >= DEPTH are dropped
INIT_DATA, 0, value written to every word during init
TIMEOUT, 255, max cycles from init_en rise to init_done before error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
reinit  in  1  one-cycle pulse: re-run memory init
init_en  out  1  level enable to init engine
init_valid  in  1  init engine write strobe
init_addr  in  ADDR_W  init engine address
init_done  in  1  init engine done level
req  in  2  per-client request, held until gnt
we  in  2  per-client write(1)/read(0)
addr0, addr1  in  ADDR_W each  client addresses
wdata0, wdata1  in  DATA_W each  client write data
gnt  out  2  one-hot grant pulse, registered
rvalid  out  2  read data valid for client i
rdata  out  DATA_W  shared read data
mem_en, mem_we  out  1 each  RAM command strobe / write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
ready  out  1  high in SERVE only
init_err  out  1  sticky init timeout flag

Behaviour:
- Reset: all outputs 0 and state RESET_INIT. The round-robin pointer points to client 0. Reset mid-operation aborts immediately; no partial command is issued.
- States:
  - RESET_INIT: next cycle goes to INIT_REQ.
  - INIT_REQ: init_en=1 and the timeout counter runs. Each init_valid with init_addr<DEPTH gives a registered RAM write (mem_en=mem_we=1, mem_addr=init_addr, mem_wdata=INIT_DATA) one cycle later. init_addr>=DEPTH is dropped; the engine emits address DEPTH once and it must not be written. init_done=1 goes to INIT_REL. Counter==TIMEOUT sets init_err=1 and goes to INIT_REL.
  - INIT_REL: init_en=0. Waits for init_done==0 (engine release takes ~4-5 cycles because of its input sync), then goes to SERVE. A second timeout here sets init_err and goes to SERVE anyway.
  - SERVE: ready=1 and arbitration runs. reinit goes to DRAIN.
  - DRAIN: issues no new grants. Waits until no command is in flight and rvalid has completed, then goes to INIT_REQ.
- Client requests are ignored (no gnt) outside SERVE.
- Arbitration:
  - Each SERVE cycle, the eligible requesters are req[i] & ~gnt[i]. A client granted this cycle is masked next cycle, so a held req is never double-granted.
  - With both eligible, the pointer client wins. The pointer then moves to the other client.
  - A winner sampled in cycle N gets gnt[i]=1 in N+1, together with the registered mem_en/mem_we/mem_addr/mem_wdata from that client's inputs in N.
  - Client drops or changes req on seeing gnt.
- Reads: rvalid[i]=1 and rdata=mem_rdata in the cycle after gnt[i] with mem_we=0. Only one rvalid is high per cycle.
- Client address >= DEPTH: granted, but mem_en is forced 0. Reads return rdata=0 with rvalid still pulsed.
- reinit during INIT_REQ/INIT_REL is ignored. reinit and req in the same SERVE cycle: reinit wins and no grant is issued.
- init_err clears only on reset.

Decomposition:
- Shared package: state encoding (RESET_INIT, INIT_REQ, INIT_REL, SERVE, DRAIN) and client index constants.
- One sub-module, rr_arb2: 2-way round-robin picker with mask input, returning a one-hot winner and pointer update.

Test Plan:
- Reset release with the real init engine attached -> init_en rises cycle 1; exactly 32 writes to addresses 0..31 with data 0; no write to 32; ready=1 after init_done falls; init_err=0.
- Both clients request continuously in SERVE with writes -> gnt alternates 01,10,01,10; mem_addr follows addr0/addr1; each client is granted at most every other cycle.
- Client0 reads address 5 after client1 writes 0xDEADBEEF to 5 -> rvalid=01 one cycle after gnt, rdata=0xDEADBEEF.
- reinit while client0 read is in flight -> that rvalid completes; no further gnt; a new sweep rewrites all 32 words to 0; a later read of address 5 returns 0.
- init_done held at 0, TIMEOUT=15 -> init_err=1 at cycle 16 after init_en rise; state proceeds to SERVE; ready=1.
- rst_n asserted mid-sweep at address 10 -> all outputs 0 asynchronously; after release a full sweep restarts from address 0.
